obstacle_manager: RTL and testbench
===================================

OBSTACLE_MANAGER -- requirements
Module: obstacle_manager

Interface
REQ-001 SHALL have parameter N_OBS, default 2, number of obstacle slots (legal 1..4).
REQ-002 SHALL have parameter POS_W, default 9, obstacle x-position width.
REQ-003 SHALL have parameter TYPE_W, default 3, obstacle type width.
REQ-004 SHALL have parameter START_POS, default 319, spawn x-position.
REQ-005 SHALL have parameter MIN_GAP, default 40, minimum ticks between spawns.
REQ-006 SHALL have parameter SPEED_MAX, default 3, maximum pixels moved per tick.
REQ-007 SHALL have parameter SPEED_TICKS, default 600, ticks per speed increment.
REQ-008 clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 i_game_tick  input  1  single-cycle frame-rate tick pulse.
REQ-011 i_game_start  input  1  single-cycle pulse starting or restarting a game.
REQ-012 i_game_over  input  1  single-cycle pulse freezing motion on crash.
REQ-013 i_rng  input  8  free-running random value.
REQ-014 o_obs_pos  output  N_OBS*POS_W  packed positions; slot k at bits [k*POS_W +: POS_W].
REQ-015 o_obs_type  output  N_OBS*TYPE_W  packed types; slot k at bits [k*TYPE_W +: TYPE_W].
REQ-016 o_obs_valid  output  N_OBS  per-slot active flag.
REQ-017 o_speed  output  2  current speed level.
REQ-018 o_spawn_pulse  output  1  one-cycle pulse when a slot is loaded.

Function
REQ-019 SHALL implement FSM IDLE, RUN, FROZEN.
- IDLE -> RUN on i_game_start.
- RUN -> FROZEN on i_game_over.
- FROZEN -> RUN on i_game_start.
REQ-020 On entry to RUN: all slots invalid; positions START_POS; types 0; speed 1; gap counter MIN_GAP; tick counter 0.
REQ-021 i_game_over and i_game_start in the same cycle SHALL be treated as i_game_over only.
REQ-022 In IDLE and FROZEN, i_game_tick SHALL be ignored and all outputs held.
REQ-023 In RUN, on each i_game_tick, every valid slot SHALL decrement its position by o_speed.
REQ-024 A valid slot whose position is less than o_speed at a tick SHALL become invalid, with position reloaded to START_POS; positions never wrap below 0.
REQ-025 Spawn condition: gap counter is 0 and at least one slot was invalid before this tick's update.
REQ-026 On spawn, the lowest-index invalid slot SHALL load START_POS and type i_rng[TYPE_W-1:0], and become valid; o_spawn_pulse SHALL be asserted.
REQ-027 A slot retired at a tick SHALL NOT be reused for spawning until the next tick.
REQ-028 On spawn, the gap counter SHALL load MIN_GAP + i_rng[7:4]; otherwise it decrements by 1 per tick, saturating at 0.
REQ-029 The tick counter SHALL count RUN ticks. On reaching SPEED_TICKS-1 it wraps to 0 and o_speed increments, saturating at SPEED_MAX.
REQ-030 All outputs SHALL be registered; updates appear the cycle after the tick edge (latency 1).
REQ-031 All arithmetic SHALL be unsigned; the position subtract is compared before update so no underflow occurs.

Reset
REQ-032 On rst: state IDLE; o_obs_valid 0; every o_obs_pos START_POS; o_obs_type 0; o_speed 1; o_spawn_pulse 0; gap counter MIN_GAP; tick counter 0.
REQ-033 rst asserted mid-game SHALL abort immediately to IDLE with no residual spawn pulse.

Structure
REQ-034 The FSM state encoding and the default speed/gap constants SHALL live in the shared game package.
REQ-035 Per-slot position/valid/type logic SHALL be one sub-module, obstacle_slot, instantiated N_OBS times via generate.
REQ-036 The implementation SHALL be one clock domain with no latches, 120-400 lines of RTL.

Verification
REQ-037 Verification SHALL cover the following scenarios:
- Reset, then 10 ticks with no i_game_start -> o_obs_valid=0, positions 319, o_speed=1.
- i_game_start, i_rng=8'h25, then 41 ticks -> slot 0 valid at pos 319 type 5, o_spawn_pulse for 1 cycle, next spawn no earlier than 40+2 ticks later.
- Slot 0 at pos 2, o_speed=3, one tick -> slot 0 invalid, pos 319, no spawn into slot 0 that tick.
- i_game_over, then 20 ticks -> all positions and valids unchanged; i_game_start -> all slots invalid, o_speed=1.
- 600*3 RUN ticks -> o_speed steps 1,2,3 and holds at 3.
- i_game_start and i_game_over in the same cycle while in RUN -> FROZEN; rst mid-RUN -> IDLE outputs in the next cycle.

Source files
------------

// File: rtl/obstacle_manager_pkg.sv
// rtl/obstacle_manager_pkg.sv - game state encoding and default speed/gap constants
package obstacle_manager_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } game_state_e;

    localparam int         DEF_MIN_GAP     = 40;
    localparam int         DEF_SPEED_MAX   = 3;
    localparam int         DEF_SPEED_TICKS = 600;
    localparam logic [1:0] SPEED_INIT      = 2'd1;

endpackage

// File: rtl/obstacle_slot.sv
// rtl/obstacle_slot.sv - one obstacle slot: position, type and active flag
module obstacle_slot #(
    parameter int POS_W     = 9,
    parameter int TYPE_W    = 3,
    parameter int START_POS = 319
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              tick_i,
    input  logic              load_i,
    input  logic [1:0]        speed_i,
    input  logic [TYPE_W-1:0] type_i,
    output logic [POS_W-1:0]  pos_o,
    output logic [TYPE_W-1:0] type_o,
    output logic              valid_o
);

    localparam logic [POS_W-1:0] START = POS_W'(START_POS);

    logic [POS_W-1:0]  pos_q, pos_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic              valid_q, valid_d;
    logic [POS_W-1:0]  step;

    assign step = POS_W'(speed_i);

    // Compare before subtracting so the position never wraps below zero.
    always_comb begin
        pos_d   = pos_q;
        type_d  = type_q;
        valid_d = valid_q;
        if (init_i) begin
            pos_d   = START;
            type_d  = '0;
            valid_d = 1'b0;
        end else if (tick_i) begin
            if (load_i) begin
                pos_d   = START;
                type_d  = type_i;
                valid_d = 1'b1;
            end else if (valid_q) begin
                if (pos_q < step) begin
                    pos_d   = START;
                    valid_d = 1'b0;
                end else begin
                    pos_d = pos_q - step;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q   <= START;
            type_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            type_q  <= type_d;
            valid_q <= valid_d;
        end
    end

    assign pos_o   = pos_q;
    assign type_o  = type_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/obstacle_manager.sv
// rtl/obstacle_manager.sv - obstacle spawn/scroll manager with game-state FSM and speed ramp
module obstacle_manager
    import obstacle_manager_pkg::*;
#(
    parameter int N_OBS       = 2,
    parameter int POS_W       = 9,
    parameter int TYPE_W      = 3,
    parameter int START_POS   = 319,
    parameter int MIN_GAP     = DEF_MIN_GAP,
    parameter int SPEED_MAX   = DEF_SPEED_MAX,
    parameter int SPEED_TICKS = DEF_SPEED_TICKS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_game_tick,
    input  logic                    i_game_start,
    input  logic                    i_game_over,
    input  logic [7:0]              i_rng,
    output logic [N_OBS*POS_W-1:0]  o_obs_pos,
    output logic [N_OBS*TYPE_W-1:0] o_obs_type,
    output logic [N_OBS-1:0]        o_obs_valid,
    output logic [1:0]              o_speed,
    output logic                    o_spawn_pulse
);

    localparam int               GAP_W     = $clog2(MIN_GAP + 16);
    localparam int               TICK_W    = $clog2(SPEED_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(MIN_GAP);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SPEED_TICKS - 1);
    localparam logic [1:0]       SPEED_TOP = 2'(SPEED_MAX);

    game_state_e       state_q, state_d;
    logic              enter_run, run_tick;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        speed_q, speed_d;
    logic              spawn_q, spawn_d;
    logic [N_OBS-1:0]  spawn_sel;
    logic              free_found, spawn_ok;
    logic              rng_unused;

    assign rng_unused = ^i_rng;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // A simultaneous start and game-over resolves as game-over.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_game_start && !i_game_over) state_d = ST_RUN;
            ST_RUN:    if (i_game_over)                  state_d = ST_FROZEN;
            ST_FROZEN: if (i_game_start && !i_game_over) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        enter_run = (state_q != ST_RUN) && (state_d == ST_RUN);
        run_tick  = (state_q == ST_RUN) && (state_d == ST_RUN) && i_game_tick;
    end

    // Pick from the pre-tick valid flags, so a slot retiring this tick stays unavailable.
    always_comb begin
        spawn_sel  = '0;
        free_found = 1'b0;
        for (int k = 0; k < N_OBS; k++) begin
            if (!o_obs_valid[k] && !free_found) begin
                spawn_sel[k] = 1'b1;
                free_found   = 1'b1;
            end
        end
    end

    assign spawn_ok = run_tick && (gap_q == '0) && free_found;

    always_comb begin
        gap_d   = gap_q;
        tick_d  = tick_q;
        speed_d = speed_q;
        spawn_d = 1'b0;
        if (enter_run) begin
            gap_d   = GAP_INIT;
            tick_d  = '0;
            speed_d = SPEED_INIT;
        end else if (run_tick) begin
            spawn_d = spawn_ok;
            if (spawn_ok)          gap_d = GAP_W'(MIN_GAP + int'(i_rng[7:4]));
            else if (gap_q != '0)  gap_d = gap_q - GAP_W'(1);
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                if (speed_q != SPEED_TOP) speed_d = speed_q + 2'd1;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q   <= GAP_INIT;
            tick_q  <= '0;
            speed_q <= SPEED_INIT;
            spawn_q <= 1'b0;
        end else begin
            gap_q   <= gap_d;
            tick_q  <= tick_d;
            speed_q <= speed_d;
            spawn_q <= spawn_d;
        end
    end

    for (genvar k = 0; k < N_OBS; k++) begin : g_slot
        obstacle_slot #(
            .POS_W     (POS_W),
            .TYPE_W    (TYPE_W),
            .START_POS (START_POS)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .init_i  (enter_run),
            .tick_i  (run_tick),
            .load_i  (spawn_ok && spawn_sel[k]),
            .speed_i (speed_q),
            .type_i  (i_rng[TYPE_W-1:0]),
            .pos_o   (o_obs_pos[k*POS_W +: POS_W]),
            .type_o  (o_obs_type[k*TYPE_W +: TYPE_W]),
            .valid_o (o_obs_valid[k])
        );
    end

    assign o_speed       = speed_q;
    assign o_spawn_pulse = spawn_q;

endmodule

// File: tb/tb_obstacle_manager.sv
// tb/tb_obstacle_manager.sv - scoreboard bench for obstacle_manager with hand-computed vectors
module tb_obstacle_manager;

    localparam logic [4:0] M_POS = 5'b00001;
    localparam logic [4:0] M_VAL = 5'b00010;
    localparam logic [4:0] M_TYP = 5'b00100;
    localparam logic [4:0] M_SPD = 5'b01000;
    localparam logic [4:0] M_SPN = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [17:0] P_RST = {9'd319, 9'd319};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        over = 1'b0;
    logic [7:0]  rng = 8'h25;
    logic [17:0] pos;
    logic [5:0]  typ;
    logic [1:0]  valid;
    logic [1:0]  speed;
    logic        spawn;

    obstacle_manager dut (
        .clk           (clk),
        .rst           (rst),
        .i_game_tick   (tick),
        .i_game_start  (start),
        .i_game_over   (over),
        .i_rng         (rng),
        .o_obs_pos     (pos),
        .o_obs_type    (typ),
        .o_obs_valid   (valid),
        .o_speed       (speed),
        .o_spawn_pulse (spawn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [4:0]  mask;
        logic [17:0] pos;
        logic [1:0]  valid;
        logic [5:0]  typ;
        logic [1:0]  speed;
        logic        spawn;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] pk(input logic [8:0] p1, input logic [8:0] p0);
        return {p1, p0};
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, fld, act, req);
        end
    endtask

    // Monitor: expectations are tagged with the cycle whose outputs they describe.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            cur = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", cur.name, cur.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            cur = sb.pop_front();
            if (cur.mask[0]) cmp(cur.name, "pos",   32'(pos),   32'(cur.pos));
            if (cur.mask[1]) cmp(cur.name, "valid", 32'(valid), 32'(cur.valid));
            if (cur.mask[2]) cmp(cur.name, "type",  32'(typ),   32'(cur.typ));
            if (cur.mask[3]) cmp(cur.name, "speed", 32'(speed), 32'(cur.speed));
            if (cur.mask[4]) cmp(cur.name, "spawn", 32'(spawn), 32'(cur.spawn));
        end
    end

    task automatic step(input logic t, input logic s, input logic o);
        tick  = t;
        start = s;
        over  = o;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        start = 1'b0;
        over  = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [4:0] mask, input logic [17:0] p,
                              input logic [1:0] v, input logic [5:0] ty, input logic [1:0] sp,
                              input logic sw);
        exp_t e;
        e.cyc   = cyc;
        e.name  = name;
        e.mask  = mask;
        e.pos   = p;
        e.valid = v;
        e.typ   = ty;
        e.speed = sp;
        e.spawn = sw;
        sb.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            expect_out("idle_tick", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);
        end

        // Game 1: first spawn, freeze on game-over, restart.
        step(1'b0, 1'b1, 1'b0);
        expect_out("g1_start", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);
        for (int t = 1; t <= 84; t++) begin
            step(1'b1, 1'b0, 1'b0);
            if (t == 40) expect_out("g1_t40", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);
            if (t == 41) begin
                expect_out("g1_t41", M_ALL, P_RST, 2'b01, 6'd5, 2'd1, 1'b1);
                step(1'b0, 1'b0, 1'b0);
                expect_out("g1_t41_next", M_ALL, P_RST, 2'b01, 6'd5, 2'd1, 1'b0);
            end
            if (t == 83) expect_out("g1_t83", M_ALL, pk(9'd319, 9'd277), 2'b01, 6'd5, 2'd1, 1'b0);
            if (t == 84) expect_out("g1_t84", M_ALL, pk(9'd319, 9'd276), 2'b11, 6'd45, 2'd1, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1);
        expect_out("g1_over", M_ALL, pk(9'd319, 9'd276), 2'b11, 6'd45, 2'd1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            expect_out("g1_frozen_tick", M_ALL, pk(9'd319, 9'd276), 2'b11, 6'd45, 2'd1, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        expect_out("g1_restart", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);

        // Game 2: speed ramp and retirement at speed 2 and 3.
        for (int t = 1; t <= 1800; t++) begin
            rng = (t == 642) ? 8'h35 : 8'h25;
            step(1'b1, 1'b0, 1'b0);
            case (t)
                599:  expect_out("g2_t599",  M_SPD, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);
                600:  expect_out("g2_t600",  M_SPD, P_RST, 2'b00, 6'd0, 2'd2, 1'b0);
                641:  expect_out("g2_t641",  M_ALL, pk(9'd42, 9'd319), 2'b10, 6'd45, 2'd2, 1'b0);
                642:  expect_out("g2_t642",  M_ALL, pk(9'd40, 9'd319), 2'b11, 6'd45, 2'd2, 1'b1);
                1199: expect_out("g2_t1199", M_SPD, P_RST, 2'b00, 6'd0, 2'd2, 1'b0);
                1200: expect_out("g2_t1200", M_ALL, pk(9'd257, 9'd169), 2'b11, 6'd45, 2'd3, 1'b0);
                1285: expect_out("g2_t1285", M_ALL, pk(9'd2, 9'd238), 2'b11, 6'd45, 2'd3, 1'b0);
                1286: expect_out("g2_t1286", M_ALL, pk(9'd319, 9'd235), 2'b01, 6'd45, 2'd3, 1'b0);
                1799: expect_out("g2_t1799", M_SPD, P_RST, 2'b00, 6'd0, 2'd3, 1'b0);
                1800: expect_out("g2_t1800", M_SPD, P_RST, 2'b00, 6'd0, 2'd3, 1'b0);
                default: ;
            endcase
        end
        rng = 8'h25;
        step(1'b0, 1'b0, 1'b1);
        expect_out("g2_over", M_SPD | M_SPN, P_RST, 2'b00, 6'd0, 2'd3, 1'b0);

        // Game 3: simultaneous start/over in RUN, then reset mid-game.
        step(1'b0, 1'b1, 1'b0);
        expect_out("g3_start", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);
        for (int t = 1; t <= 41; t++) step(1'b1, 1'b0, 1'b0);
        expect_out("g3_t41", M_ALL, P_RST, 2'b01, 6'd5, 2'd1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        expect_out("g3_start_over", M_ALL, P_RST, 2'b01, 6'd5, 2'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("g3_frozen_tick", M_ALL, P_RST, 2'b01, 6'd5, 2'd1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("g4_start", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);
        for (int t = 1; t <= 41; t++) step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        expect_out("g4_rst_mid", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int t = 1; t <= 45; t++) step(1'b1, 1'b0, 1'b0);
        expect_out("post_rst_idle", M_ALL, P_RST, 2'b00, 6'd0, 2'd1, 1'b0);

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
